sipo_deframer: RTL and testbench
================================

// Module: sipo_deframer
// PURPOSE
// - Serial-to-parallel receiver; consumes the 1-bit stream produced by piso.
// - Hunts for a sync word, then reassembles fixed-width words LSB-first.
// - Presents each word on a valid/ready output register for the parallel consumer.
// PARAMETERS
// - WIDTH      4      data bits per frame (>=2)
// - SYNC_LEN   8      sync word length in bits (2..16)
// - SYNC_WORD  8'hA5  sync pattern; bit 0 arrives first
// PORTS
// - clock      in   1      rising-edge clock
// - reset      in   1      synchronous, active-high
// - serial_in  in   1      serial data; sampled only when bit_en=1
// - bit_en     in   1      bit strobe; one serial bit per high cycle
// - out_data   out  WIDTH  assembled word; bit 0 = first received bit
// - out_valid  out  1      out_data holds an unconsumed word
// - out_ready  in   1      consumer accepts the word when out_valid & out_ready
// - sync_lock  out  1      high while in LOCKED state
// - overrun    out  1      one-cycle pulse: completed word dropped (output full)
// - parity_err out  1      one-cycle pulse (PARITY_CHECK_EN only, else tied 0)
// BEHAVIOUR
// - Reset (sync, active-high): all outputs 0; state=HUNT; sync window, shift reg, counter cleared.
// - Reset mid-frame or mid-handshake: partial frame and pending word discarded; no overrun pulse.
// - bit_en=0 cycles: state, counters and shift regs hold; the handshake still operates.
// - HUNT: each bit_en shifts serial_in into a SYNC_LEN window (new bit enters MSB, shifts right).
// - Window == SYNC_WORD after the shift -> LOCKED next cycle; bit counter=0; the sync bits are not data.
// - LOCKED: each bit_en stores serial_in at shift[count]; count increments.
// - On the bit_en cycle that writes bit WIDTH-1, the word completes; count wraps to 0.
// - The next frame starts on the following bit_en; no resync between frames.
// - Word completion, output empty or accepted in the same cycle: next cycle out_data=word, out_valid=1.
// - Latency: one clock after the bit_en of the last data bit.
// - Word completion while out_valid=1 and out_ready=0:
//   - New word dropped; out_data/out_valid unchanged.
//   - overrun=1 for exactly one cycle; lock is kept.
// - Accept with no completion: out_valid -> 0 next cycle; out_data holds its last value.
// - out_data must not change while out_valid=1 and out_ready=0.
// - Counter width is $clog2(WIDTH+1); no other arithmetic.
// - sync_lock is a registered copy of (state==LOCKED).
// CONFIGURATION
// - Macro PARITY_CHECK_EN.
// - Defined:
//   - Each frame is WIDTH+1 bits; the last bit makes the frame's total parity even.
//   - Word is delivered only if parity is good; delivery and overrun rules are unchanged.
//   - Bad parity: word discarded; parity_err=1 for one cycle; state -> HUNT with the window cleared.
//   - If bad parity coincides with output full, only parity_err pulses, not overrun.
// - Undefined:
//   - Frames are WIDTH bits; no parity bit.
//   - parity_err is tied 0; the block never leaves LOCKED except through reset.
// TESTING
// - Reset: hold reset 3 cycles with random serial_in/bit_en -> all outputs 0; sync_lock=0.
// - Lock + word:
//   - Stimulus: bits of 8'hA5 LSB-first, then 1,0,1,1 with bit_en every cycle, out_ready=1.
//   - Response: sync_lock=1; out_data=4'hD; out_valid for 1 cycle, one clock after the last bit.
// - Backpressure:
//   - Stimulus: locked, out_ready=0; send 4'h3 then 4'hC.
//   - Response: out_data stays 4'h3; overrun pulses once at the 4'hC completion; 4'h3 accepted once out_ready=1.
// - Simultaneous:
//   - Stimulus: out_ready=1 on the same cycle 4'h9 completes while 4'h6 is pending.
//   - Response: 4'h6 accepted; next cycle out_data=4'h9, out_valid=1, no overrun.
// - Gapped strobe + near-miss sync:
//   - Stimulus: bit_en every 3rd cycle; a 7-of-8 partial 8'hA5, then the full pattern.
//   - Response: lock only after the full pattern; the word value is unaffected by idle cycles.
// - PARITY_CHECK_EN:
//   - Stimulus: frame 4'hB + parity 1, then 4'hB + parity 0.
//   - Response: first delivers 4'hB; second pulses parity_err, no out_valid, sync_lock drops.

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: hunts for SYNC_WORD, then assembles WIDTH-bit words LSB-first
// onto a valid/ready output register. Optional even-parity frame check with PARITY_CHECK_EN.
module sipo_deframer #(
  parameter int                  WIDTH     = 4,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_lock,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [SYNC_LEN-1:0] win_q,   win_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WIDTH-1:0]    data_q,  data_d;
  logic                valid_q, valid_d;
  logic                lock_q,  lock_d;
  logic                ovr_q,   ovr_d;
  logic                complete;
  logic                par_ok;
`ifdef PARITY_CHECK_EN
  logic                perr_q,  perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    shift_d  = shift_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    complete = 1'b0;
    par_ok   = 1'b1;
`ifdef PARITY_CHECK_EN
    perr_d   = 1'b0;
`endif

    if (bit_en) begin
      if (state_q == ST_HUNT) begin
        win_d = {serial_in, win_q[SYNC_LEN-1:1]};
        if (win_d == SYNC_WORD) begin
          state_d = ST_LOCKED;
          count_d = '0;
        end
      end else begin
        // The parity bit (count == WIDTH) is never stored in the data register.
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (count_q == CW'(i)) shift_d[i] = serial_in;
        end
        if (count_q == LAST_IDX) begin
          complete = 1'b1;
          count_d  = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end

`ifdef PARITY_CHECK_EN
    // Frame parity is the data word plus the incoming parity bit; must be even.
    par_ok = ~(^shift_q ^ serial_in);
    if (complete && !par_ok) begin
      perr_d  = 1'b1;
      state_d = ST_HUNT;
      win_d   = '0;
    end
`endif

    if (complete && par_ok) begin
      if (!valid_q || out_ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HUNT;
      win_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sync_lock = lock_q;
  assign overrun   = ovr_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed table, hand-written corner sequences and random
// traffic, all checked against a bit-queue reference model.
module tb_sipo_deframer;

  localparam int WIDTH    = 4;
  localparam int SYNC_LEN = 8;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR   = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, serial_in, bit_en, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, sync_lock, overrun, parity_err;

  int total = 0;
  int bad   = 0;

  bit          m_lock, m_valid, m_ovr, m_perr;
  int unsigned m_data;
  bit          hist[$];
  bit          fr[$];

  typedef struct {
    bit       rst, sin, en, rdy;
    bit       e_valid;
    bit [3:0] e_data;
    bit       e_lock;
    bit       e_ovr;
  } vec_t;
  vec_t tbl[$];

  sipo_deframer #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sync_lock(sync_lock), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned win_val();
    int unsigned v = 0;
    for (int j = 0; j < hist.size(); j++)
      v |= int'(hist[j]) << (SYNC_LEN - hist.size() + j);
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit e, input bit k);
    bit done = 1'b0, good = 1'b1, p = 1'b0;
    int unsigned w = 0;
    if (r) begin
      m_lock = 0; m_valid = 0; m_data = 0; m_ovr = 0; m_perr = 0;
      hist.delete(); fr.delete();
      return;
    end
    m_ovr = 0; m_perr = 0;
    if (e) begin
      if (!m_lock) begin
        hist.push_back(s);
        if (hist.size() > SYNC_LEN) void'(hist.pop_front());
        if (win_val() == SYNC) begin m_lock = 1; fr.delete(); end
      end else begin
        fr.push_back(s);
        if (fr.size() == FRAME) begin
          done = 1;
          for (int i = 0; i < FRAME; i++) begin
            if (i < WIDTH) w |= int'(fr[i]) << i;
            p ^= fr[i];
          end
          good = PAR ? (p == 1'b0) : 1'b1;
          fr.delete();
        end
      end
    end
    if (done && !good) begin m_perr = 1; m_lock = 0; hist.delete(); end
    if (done && good) begin
      if (!m_valid || k) begin m_data = w; m_valid = 1; end
      else m_ovr = 1;
    end else if (m_valid && k) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit e, input bit k);
    reset = r; serial_in = s; bit_en = e; out_ready = k;
    @(posedge clock);
    model_edge(r, s, e, k);
    @(negedge clock);
    check("valid", out_valid, m_valid);
    check("data", out_data, m_data);
    check("lock", sync_lock, m_lock);
    check("ovr", overrun, m_ovr);
    check("perr", parity_err, m_perr);
  endtask

  task automatic send_frame(input int unsigned v, input int n, input bit k,
                            input bit k_last, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) step(0, 0, 0, k);
      step(0, bit'((v >> i) & 1), 1, (i == n - 1) ? k_last : k);
    end
  endtask

  task automatic send_word(input int unsigned v, input bit k, input bit k_last, input int gap);
    int unsigned f = v;
    if (PAR) f = v | ((($countones(v) & 1) != 0 ? 1 : 0) << WIDTH);
    send_frame(f, FRAME, k, k_last, gap);
  endtask

  task automatic push_row(input bit s, input bit e, input bit v, input bit [3:0] d, input bit l);
    vec_t r;
    r.rst = 0; r.sin = s; r.en = e; r.rdy = 1;
    r.e_valid = v; r.e_data = d; r.e_lock = l; r.e_ovr = 0;
    tbl.push_back(r);
  endtask

  initial begin
    bit [7:0] sb;
    sb = SYNC;
    for (int i = 0; i < 8; i++) push_row(sb[i], 1, 0, 4'h0, i == 7);
    push_row(1, 1, 0, 4'h0, 1);
    push_row(0, 1, 0, 4'h0, 1);
    push_row(1, 1, 0, 4'h0, 1);
`ifdef PARITY_CHECK_EN
    push_row(1, 1, 0, 4'h0, 1);
    push_row(1, 1, 1, 4'hD, 1);
`else
    push_row(1, 1, 1, 4'hD, 1);
`endif
    push_row(0, 0, 0, 4'hD, 1);
    push_row(0, 0, 0, 4'hD, 1);

    reset = 1; serial_in = 0; bit_en = 0; out_ready = 0;

    // Reset with random serial traffic
    for (int i = 0; i < 3; i++) begin
      step(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_lock", sync_lock, 0);
      check("rst_ovr", overrun, 0);
      check("rst_perr", parity_err, 0);
    end

    // Lock + first word
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sin, tbl[i].en, tbl[i].rdy);
      check("tbl_valid", out_valid, tbl[i].e_valid);
      check("tbl_data", out_data, tbl[i].e_data);
      check("tbl_lock", sync_lock, tbl[i].e_lock);
      check("tbl_ovr", overrun, tbl[i].e_ovr);
    end

    // Backpressure: 4'h3 held, 4'hC dropped with one overrun pulse
    send_word(4'h3, 0, 0, 0);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data", out_data, 4'h3);
    send_word(4'hC, 0, 0, 0);
    check("bp_ovr_pulse", overrun, 1);
    check("bp_data_held", out_data, 4'h3);
    check("bp_lock_kept", sync_lock, 1);
    step(0, 0, 0, 0);
    check("bp_ovr_end", overrun, 0);
    check("bp_data_still", out_data, 4'h3);
    step(0, 0, 0, 1);
    check("bp_accept_valid", out_valid, 0);
    check("bp_accept_data", out_data, 4'h3);

    // Accept 4'h6 on the same edge 4'h9 completes
    send_word(4'h6, 0, 0, 0);
    check("sim_pending", out_data, 4'h6);
    send_word(4'h9, 0, 1, 0);
    check("sim_valid", out_valid, 1);
    check("sim_data", out_data, 4'h9);
    check("sim_no_ovr", overrun, 0);
    step(0, 0, 0, 1);

    // Gapped strobe with a 7-of-8 near-miss before the real sync word
    step(1, 0, 0, 0);
    send_frame(8'h25, SYNC_LEN, 1, 1, 2);
    check("gap_nearmiss_lock", sync_lock, 0);
    send_frame(SYNC, SYNC_LEN, 1, 1, 2);
    check("gap_lock", sync_lock, 1);
    send_word(4'hA, 1, 1, 2);
    check("gap_valid", out_valid, 1);
    check("gap_data", out_data, 4'hA);
    step(0, 0, 0, 1);

    // Reset mid-frame with a pending word
    send_word(4'h5, 0, 0, 0);
    send_frame(3, 2, 0, 0, 0);
    step(1, 1, 1, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_lock", sync_lock, 0);
    check("midrst_data", out_data, 0);

`ifdef PARITY_CHECK_EN
    send_frame(SYNC, SYNC_LEN, 1, 1, 0);
    send_frame(5'h1B, 5, 1, 1, 0);
    check("par_good_valid", out_valid, 1);
    check("par_good_data", out_data, 4'hB);
    check("par_good_perr", parity_err, 0);
    step(0, 0, 0, 1);
    send_frame(5'h0B, 5, 1, 1, 0);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_valid", out_valid, 0);
    check("par_bad_lock", sync_lock, 0);
    step(0, 0, 0, 1);
    check("par_perr_end", parity_err, 0);
`endif

    // Random traffic against the model
    for (int round = 0; round < 8; round++) begin
      step(1, 0, 0, 0);
      send_frame(SYNC, SYNC_LEN, 1, 1, 0);
      for (int c = 0; c < 200; c++)
        step($urandom_range(0, 96) == 0, bit'($urandom_range(0, 1)),
             $urandom_range(0, 2) != 0, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
